// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the instruction fetch queue:
//   fb_entry_t          - one fetched instruction (PC plus raw encoding)
//   FETCH_WIDTH_DEF     - default lanes per fetch packet
//   DECODE_WIDTH_DEF    - default lanes presented to decode
//   IB_ADDR / DEPTH_DEF - queue depth expressed as an address width
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fb_entry_t;

    localparam int FETCH_WIDTH_DEF  = 4;
    localparam int DECODE_WIDTH_DEF = 4;
    localparam int IB_ADDR          = 4;
    localparam int DEPTH_DEF        = 2 ** IB_ADDR;

endpackage : fetch_queue_pkg

// File: rtl/fetch_lane_compact.sv
// -----------------------------------------------------------------------------
// fetch_lane_compact
// Combinational lane compaction helper. For each lane of a fetch packet it
// produces the number of valid lanes older than it (exclusive prefix
// popcount), which is that lane's write offset from the queue tail, plus the
// total number of valid lanes.
// Ports:
//   in_mask     in   per-lane valid mask, lane 0 oldest
//   lane_offset out  exclusive prefix popcount per lane
//   total       out  popcount of in_mask
// -----------------------------------------------------------------------------
module fetch_lane_compact #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         in_mask,
    output logic [W-1:0][CW-1:0] lane_offset,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    // NOTE: combinational blocks use blocking '=' so each lane sees the running
    // sum from the previous iteration; every output gets a default first so no
    // latch is inferred.
    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            lane_offset[i] = acc;
            acc            = acc + CW'(in_mask[i]);
        end
        total = acc;
    end

endmodule : fetch_lane_compact

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular instruction queue between fetch and decode. Only the valid lanes of
// a fetch packet are stored, packed in program order; decode sees up to
// DECODE_WIDTH oldest entries and consumes a variable number per cycle.
// Ports:
//   clock, reset (sync, active-low)
//   flush        drop all contents on the next edge (overrides enq/deq)
//   in_entries / in_mask / in_valid / in_ready   fetch packet handshake
//   out_entries / out_valid                      oldest entries, thermometer
//   deq_count    entries consumed by decode this cycle
//   count        current occupancy
//   full         ~in_ready, fetch stall
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int FETCH_WIDTH  = FETCH_WIDTH_DEF,
    parameter int DECODE_WIDTH = DECODE_WIDTH_DEF,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 flush,
    input  fb_entry_t [FETCH_WIDTH-1:0]          in_entries,
    input  logic [FETCH_WIDTH-1:0]               in_mask,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output fb_entry_t [DECODE_WIDTH-1:0]         out_entries,
    output logic [DECODE_WIDTH-1:0]              out_valid,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]    deq_count,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic                                 full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(FETCH_WIDTH + 1);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    fb_entry_t     mem_q [DEPTH];
    fb_entry_t     mem_d [DEPTH];

    logic [FETCH_WIDTH-1:0][FW-1:0] lane_offset;
    logic [FW-1:0]                  enq_total;
    logic [CW-1:0]                  free_slots;
    logic [CW-1:0]                  deq_eff;
    logic                           clear;
    logic                           enq_do;

    fetch_lane_compact #(
        .W  (FETCH_WIDTH),
        .CW (FW)
    ) u_compact (
        .in_mask     (in_mask),
        .lane_offset (lane_offset),
        .total       (enq_total)
    );

    always_comb begin
        // Readiness looks only at registered occupancy, so a full-width packet
        // always fits regardless of what decode does this cycle.
        free_slots = CW'(DEPTH) - count_q;
        in_ready   = (free_slots >= CW'(FETCH_WIDTH));
        full       = ~in_ready;

        clear   = flush | ~reset;
        enq_do  = in_valid & in_ready & ~clear;
        deq_eff = (CW'(deq_count) > count_q) ? count_q : CW'(deq_count);

        mem_d = mem_q;
        if (enq_do) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (in_mask[i]) begin
                    mem_d[tail_q + AW'(lane_offset[i])] = in_entries[i];
                end
            end
        end

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointer arithmetic wraps naturally at AW bits (DEPTH is 2^AW).
            head_d  = head_q + AW'(deq_eff);
            tail_d  = enq_do ? tail_q + AW'(enq_total) : tail_q;
            count_d = count_q + (enq_do ? CW'(enq_total) : '0) - deq_eff;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; occupancy alone decides which slots are
    // meaningful, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            out_entries[i] = mem_q[head_q + AW'(i)];
            out_valid[i]   = (CW'(i) < count_q);
        end
        count = count_q;
    end

    // Decode asking for more than is present is clamped; flag it in simulation.
    always_ff @(posedge clock) begin
        assert (!reset || flush || (CW'(deq_count) <= count_q))
        else $warning("fetch_queue: over-dequeue clamped, deq_count=%0d count=%0d",
                      deq_count, count_q);
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed self-checking bench for fetch_queue with the default geometry
// (FETCH_WIDTH=4, DECODE_WIDTH=4, DEPTH=16).
// -----------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic            clock;
    logic            reset;
    logic            flush;
    fb_entry_t [3:0] in_entries;
    logic [3:0]      in_mask;
    logic            in_valid;
    logic            in_ready;
    fb_entry_t [3:0] out_entries;
    logic [3:0]      out_valid;
    logic [2:0]      deq_count;
    logic [4:0]      count;
    logic            full;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_queue dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_entries  (in_entries),
        .in_mask     (in_mask),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_entries (out_entries),
        .out_valid   (out_valid),
        .deq_count   (deq_count),
        .count       (count),
        .full        (full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic fb_entry_t mk(input int id);
        fb_entry_t e;
        e.pc   = 32'h0000_1000 + 32'(id) * 32'd4;
        e.inst = 32'hA000_0000 | 32'(id);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: drive the inputs, take the edge, release to idle 1 time unit
    // later so checks sample well clear of the next edge.
    task automatic cyc(input logic v, input logic [3:0] m, input int base,
                       input int dq, input logic fl = 1'b0, input logic rs = 1'b1);
        in_valid  = v;
        in_mask   = m;
        deq_count = 3'(dq);
        flush     = fl;
        reset     = rs;
        for (int i = 0; i < 4; i++) in_entries[i] = mk(base + i);
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        in_mask   = 4'b0000;
        deq_count = 3'd0;
        flush     = 1'b0;
        reset     = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_mask    = 4'b0000;
        deq_count  = 3'd0;
        in_entries = '0;

        // Reset held for two cycles
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'b0000);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Compaction: mask 1011 keeps lanes 0,1,3 -> A,B,D
        cyc(1'b1, 4'b1011, 1, 0);
        check("cmp_count", 64'(count), 64'd3);
        check("cmp_out0", 64'(out_entries[0]), 64'(mk(1)));
        check("cmp_out1", 64'(out_entries[1]), 64'(mk(2)));
        check("cmp_out2", 64'(out_entries[2]), 64'(mk(4)));
        check("cmp_out_valid", 64'(out_valid), 64'b0111);
        cyc(1'b0, 4'b0000, 0, 3);
        check("cmp_drain", 64'(count), 64'd0);

        // Full boundary: four full packets
        cyc(1'b1, 4'b1111, 16'h10, 0);
        cyc(1'b1, 4'b1111, 16'h14, 0);
        cyc(1'b1, 4'b1111, 16'h18, 0);
        check("fill12_ready", 64'(in_ready), 64'd1);
        cyc(1'b1, 4'b1111, 16'h1C, 0);
        check("fill16_count", 64'(count), 64'd16);
        check("fill16_ready", 64'(in_ready), 64'd0);
        check("fill16_full", 64'(full), 64'd1);
        cyc(1'b1, 4'b1111, 16'h80, 0);
        check("fill16_ignored", 64'(count), 64'd16);
        check("fill16_head", 64'(out_entries[0]), 64'(mk(16'h10)));
        cyc(1'b0, 4'b0000, 0, 4);
        check("drain_head", 64'(out_entries[0]), 64'(mk(16'h14)));
        cyc(1'b0, 4'b0000, 0, 4);
        cyc(1'b0, 4'b0000, 0, 4);
        cyc(1'b0, 4'b0000, 0, 4);
        check("drain_count", 64'(count), 64'd0);

        // Full boundary: 4 + 3*3 = 13 leaves 3 free slots, not enough for a packet
        cyc(1'b1, 4'b1111, 16'h20, 0);
        cyc(1'b1, 4'b0111, 16'h24, 0);
        cyc(1'b1, 4'b0111, 16'h28, 0);
        cyc(1'b1, 4'b0111, 16'h2C, 0);
        check("fill13_count", 64'(count), 64'd13);
        check("fill13_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 4'b1111, 16'h80, 0);
        check("fill13_ignored", 64'(count), 64'd13);
        cyc(1'b0, 4'b0000, 0, 1);
        check("deq1_count", 64'(count), 64'd12);
        check("deq1_ready", 64'(in_ready), 64'd1);
        check("deq1_head", 64'(out_entries[0]), 64'(mk(16'h21)));

        // Wrap: reset to zero pointers, then walk head=tail to 14
        cyc(1'b0, 4'b0000, 0, 0, 1'b0, 1'b0);
        check("wrap_rst_count", 64'(count), 64'd0);
        cyc(1'b1, 4'b0001, 16'h30, 0);
        for (int k = 1; k < 14; k++) cyc(1'b1, 4'b0001, 16'h30 + k, 1);
        cyc(1'b0, 4'b0000, 0, 1);
        check("wrap_preset_count", 64'(count), 64'd0);
        cyc(1'b1, 4'b1111, 16'h40, 0);   // slots 14,15,0,1
        check("wrap_count", 64'(count), 64'd4);
        check("wrap_out0", 64'(out_entries[0]), 64'(mk(16'h40)));
        check("wrap_out1", 64'(out_entries[1]), 64'(mk(16'h41)));
        check("wrap_out2", 64'(out_entries[2]), 64'(mk(16'h42)));
        check("wrap_out3", 64'(out_entries[3]), 64'(mk(16'h43)));
        cyc(1'b1, 4'b1111, 16'h50, 4);   // slots 2..5 in, 14..1 out
        check("wrap_sim_count", 64'(count), 64'd4);
        check("wrap_sim_out0", 64'(out_entries[0]), 64'(mk(16'h50)));
        check("wrap_sim_out3", 64'(out_entries[3]), 64'(mk(16'h53)));

        // Over-dequeue: count 2, ask for 4 -> head moves by 2 only
        cyc(1'b0, 4'b0000, 0, 2);
        check("ovr_pre_count", 64'(count), 64'd2);
        check("ovr_pre_out0", 64'(out_entries[0]), 64'(mk(16'h52)));
        cyc(1'b0, 4'b0000, 0, 4);
        check("ovr_count", 64'(count), 64'd0);
        check("ovr_out_valid", 64'(out_valid), 64'b0000);
        cyc(1'b1, 4'b0001, 16'h60, 0);   // lands in slot 6, head must be there too
        check("ovr_head", 64'(out_entries[0]), 64'(mk(16'h60)));
        check("ovr_post_count", 64'(count), 64'd1);

        // Flush with same-cycle enqueue and dequeue
        cyc(1'b1, 4'b1111, 16'h70, 0);
        cyc(1'b1, 4'b1111, 16'h74, 0);
        check("fl_pre_count", 64'(count), 64'd9);
        cyc(1'b1, 4'b1111, 16'h90, 3, 1'b1, 1'b1);
        check("fl_count", 64'(count), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'b0000);
        check("fl_ready", 64'(in_ready), 64'd1);
        cyc(1'b1, 4'b0001, 16'hA0, 0);
        check("fl_resume", 64'(out_entries[0]), 64'(mk(16'hA0)));

        // Mid-operation reset with same-cycle enqueue and dequeue
        cyc(1'b1, 4'b1111, 16'hB0, 0);
        cyc(1'b1, 4'b1111, 16'hB4, 0);
        check("mr_pre_count", 64'(count), 64'd9);
        cyc(1'b1, 4'b1111, 16'hC0, 3, 1'b0, 1'b0);
        check("mr_count", 64'(count), 64'd0);
        check("mr_out_valid", 64'(out_valid), 64'b0000);
        check("mr_ready", 64'(in_ready), 64'd1);
        check("mr_full", 64'(full), 64'd0);
        cyc(1'b1, 4'b0001, 16'hD0, 0);
        check("mr_resume", 64'(out_entries[0]), 64'(mk(16'hD0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_queue
